// File: rtl/mem_load_unit.sv
// mem_load_unit: load-side data path between the MEM stage and the
// synchronous DMEM/IMEM/IO memory. It accepts a byte address plus funct3,
// reads the addressed word (or two words for a misaligned access that
// crosses a word boundary), then returns the byte, halfword or word
// right-aligned and sign- or zero-extended.
//
// Optional feature macro: LOAD_MISALIGN_EN
//   defined   - LH/LW are legal at any offset; word-crossing accesses take
//               a second memory read through the WAIT1 state.
//   undefined - only naturally aligned LH/LW are legal. Anything else takes
//               the error path, and no WAIT1 logic is built.
module mem_load_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_funct3_i,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_data_o,
    output logic                  resp_err_o
);

    localparam int WW = ADDR_WIDTH - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT0 = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
`ifdef LOAD_MISALIGN_EN
    localparam logic [1:0] WAIT1 = 2'd3;
    localparam logic       MISALIGN_EN = 1'b1;
`else
    localparam logic       MISALIGN_EN = 1'b0;
`endif

    localparam logic [WW-1:0] WORD_ONE = {{(WW-1){1'b0}}, 1'b1};

    // A request is legal when funct3 names a real load and its offset is
    // allowed for the access size in this build.
    function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: is_legal = 1'b1;
            3'b001, 3'b101: is_legal = MISALIGN_EN | ~off[0];
            3'b010:         is_legal = MISALIGN_EN | (off == 2'b00);
            default:        is_legal = 1'b0;
        endcase
    endfunction

    // Shift the addressed bytes down to bit 0 and extend to 32 bits.
    // The upper word of pair only matters for word-crossing accesses.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   extract = {{24{sh[7]  & ~f3[2]}}, sh[7:0]};
            2'b01:   extract = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

`ifdef LOAD_MISALIGN_EN
    // An access crosses into the next word when off + size > 4.
    function automatic logic is_cross(input logic [2:0] f3, input logic [1:0] off);
        is_cross = ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction
`endif

    logic [1:0]    state_q,  state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q,    off_d;
    logic [WW-1:0] waddr_q,  waddr_d;
    logic [31:0]   data_q,   data_d;
    logic          err_q,    err_d;
`ifdef LOAD_MISALIGN_EN
    logic [31:0]   worda_q,  worda_d;
`endif
    logic          req_legal;

    // Next-state, capture and memory-strobe logic for the load FSM.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        data_d     = data_q;
        err_d      = err_q;
`ifdef LOAD_MISALIGN_EN
        worda_d    = worda_q;
`endif
        mem_re_o   = 1'b0;
        mem_addr_o = req_addr_i[ADDR_WIDTH-1:2];
        req_legal  = is_legal(req_funct3_i, req_addr_i[1:0]);

        case (state_q)
            IDLE: begin
                mem_re_o = req_valid_i && req_legal;
                if (req_valid_i) begin
                    funct3_d = req_funct3_i;
                    off_d    = req_addr_i[1:0];
                    waddr_d  = req_addr_i[ADDR_WIDTH-1:2];
                    if (req_legal) begin
                        state_d = WAIT0;
                    end else begin
                        state_d = DONE;
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT0: begin
                mem_addr_o = waddr_q;
`ifdef LOAD_MISALIGN_EN
                if (is_cross(funct3_q, off_q)) begin
                    mem_re_o   = 1'b1;
                    mem_addr_o = waddr_q + WORD_ONE;
                    worda_d    = mem_rdata_i;
                    state_d    = WAIT1;
                end else
`endif
                begin
                    data_d  = extract({32'd0, mem_rdata_i}, off_q, funct3_q);
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
`ifdef LOAD_MISALIGN_EN
            WAIT1: begin
                mem_addr_o = waddr_q + WORD_ONE;
                data_d     = extract({mem_rdata_i, worda_q}, off_q, funct3_q);
                err_d      = 1'b0;
                state_d    = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            waddr_q  <= '0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
`ifdef LOAD_MISALIGN_EN
            worda_q  <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            err_q    <= err_d;
`ifdef LOAD_MISALIGN_EN
            worda_q  <= worda_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load-side counterpart to the core's store byte-enable logic: accepts a load request from the MEM stage (byte address plus funct3), reads the synchronous DMEM/IMEM/IO memory, and returns the addressed byte, halfword or word. The result is right-aligned and sign- or zero-extended for writeback. The block is a small FSM with a registered response. Misaligned word-crossing loads are optionally split into two memory reads.

## Interface
- ADDR_WIDTH, 32, byte address width; the memory word address is ADDR_WIDTH-2 bits.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_WIDTH  byte address (ALU result).
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
- mem_re  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH-2  word address for the read.
- mem_rdata  in  32  memory data, valid the cycle after the mem_re cycle.
- resp_valid  out  1  one-cycle pulse; resp_data/resp_err valid.
- resp_data  out  32  extended load result.
- resp_err  out  1  illegal funct3 or unsupported alignment.

## Operation
- Accept: req_valid && req_ready. Access size is 1/2/4 bytes. off = req_addr[1:0].
- mem_re and mem_addr are combinational in IDLE:
  - mem_re = req_valid && request legal.
  - mem_addr = req_addr[ADDR_WIDTH-1:2].
- Capture on accept: funct3, off, word address.
- States:
  - IDLE: on accept, go to WAIT0 if legal, else go to DONE with err=1 and data=0 (no memory read).
  - WAIT0: mem_rdata = word A.
    - Non-crossing: extract bytes [off .. off+size-1], extend, register result, go to DONE.
    - Crossing (off+size>4): latch A, drive mem_re=1 with mem_addr = captured word address +1, go to WAIT1.
  - WAIT1: mem_rdata = word B. Result = low size bytes of ({B,A} >> 8*off), extended, registered. Go to DONE.
  - DONE: resp_valid=1 for one cycle, go to IDLE.
- Extension: LB/LH replicate bit 7/15; LBU/LHU fill with zeros; LW is passed through unchanged.
- Word address +1 wraps modulo 2^(ADDR_WIDTH-2); all-ones wraps to 0.
- resp_data and resp_err hold their value until the next DONE.
- req_ready=0 in WAIT0/WAIT1/DONE; requests presented then are ignored, not queued.
- Reset, including mid-operation: state returns to IDLE, any pending response is dropped, resp_valid=0, resp_data=0, resp_err=0, req_ready=1, mem_re=0 unless req_valid is high.

## Timing
- Accept edge = cycle 0.
- Non-crossing legal load: resp_valid in cycle 2.
- Crossing load (macro on): second read issued in cycle 1, resp_valid in cycle 3.
- Error: resp_valid in cycle 1.
- Earliest next accept is the cycle after DONE.
- Memory contract: one-cycle synchronous read. mem_rdata is used only in the cycle after the read strobe.

## Configuration
- LOAD_MISALIGN_EN defined:
  - LH is legal at any offset; LW is legal at any offset.
  - Non-crossing accesses use one read; crossing accesses (LH off=3, LW off≠0) use two reads.
- LOAD_MISALIGN_EN undefined:
  - Only natural alignment is legal: LH at off 0/2, LW at off 0, LB/LBU at any offset.
  - Other cases take the error path (resp_err=1, resp_data=0, no mem_re). WAIT1 is not synthesized.

## Test plan
- Memory[0x100]=0x8899AABB. LB at 0x103 → resp_data=0xFFFFFF88, resp_valid in cycle 2. LBU at 0x103 → 0x00000088.
- LH at 0x102 → 0xFFFF8899. LHU at 0x100 → 0x0000AABB. req_ready=0 in cycles 1–2.
- LW at 0x100 → 0x8899AABB, resp_err=0, mem_addr=0x40 with mem_re for exactly one cycle.
- With LOAD_MISALIGN_EN, memory[0x104]=0x11223344: LW at 0x103 → mem_addr 0x40 in cycle 0 then 0x41 in cycle 1, resp_data=0x22334488 in cycle 3. Without LOAD_MISALIGN_EN: resp_err=1, resp_data=0 in cycle 1, mem_re never asserted.
- funct3=011 at 0x100 → resp_err=1, resp_data=0, resp_valid in cycle 1, no mem_re.
- LW accepted, rst pulsed in WAIT0 → no resp_valid afterwards. req_ready=1 and outputs zero during reset. A new LW after release completes normally.
